// File: rtl/kyber_pkg.sv
// Shared Kyber512 constants and the reader FSM state encoding.
package kyber_pkg;

  localparam int KYBER_Q        = 3329;
  localparam int DU             = 10;
  localparam int COEF_W         = 12;
  localparam int COEFS_PER_WORD = 8;
  localparam int N_WORDS        = 64;
  localparam int WORD_W         = COEF_W * COEFS_PER_WORD;
  localparam int CT_W           = DU * COEFS_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/compress_du10_x8.sv
// Combinational Compress_q(x, du=10) over the 8 coefficient lanes of one poly word.
module compress_du10_x8
  import kyber_pkg::*;
(
  input  logic [WORD_W-1:0] coef_word,
  output logic [CT_W-1:0]   ct_word
);

  // Division by q is replaced by a multiply with ceil(2^34/q) and a 34-bit
  // shift. The numerator stays below 2^23 for every 12-bit lane, and the
  // reciprocal error times that bound is well under 2^34, so the quotient is
  // exact across the whole 0..4095 input range, not just 0..q-1.
  localparam int          SHIFT = 34;
  localparam logic [45:0] MAGIC =
    46'(((64'd1 << SHIFT) + 64'(KYBER_Q) - 64'd1) / 64'(KYBER_Q));
  localparam logic [45:0] HALF_Q = 46'((KYBER_Q - 1) / 2);

  function automatic logic [DU-1:0] compress_lane(input logic [COEF_W-1:0] x);
    logic [45:0] num;
    num = (46'(x) << DU) + HALF_Q;
    return DU'((num * MAGIC) >> SHIFT);
  endfunction

  // Lane i of the output comes from lane i of the input, lane 0 in the LSBs.
  always_comb begin
    ct_word = '0;
    for (int i = 0; i < COEFS_PER_WORD; i++) begin
      ct_word[DU*i +: DU] = compress_lane(coef_word[COEF_W*i +: COEF_W]);
    end
  end

endmodule

// File: rtl/enc_u_compress_reader.sv
// Streams the u vector out of the poly BRAM: read, compress to du=10, and
// hand the 80-bit words to the packer over valid/ready through a 2-deep FIFO.
module enc_u_compress_reader
  import kyber_pkg::*;
#(
  parameter int N_WORDS = 64,
  parameter int AW      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     M0_RAd,
  input  logic [WORD_W-1:0] M0_RData,
  output logic [CT_W-1:0]   ct_WData,
  output logic [AW-1:0]     ct_WAd,
  output logic              ct_valid,
  input  logic              ct_ready
);

  state_t          state;
  logic [AW-1:0]   rd_cnt;
  logic [AW-1:0]   inflight_idx;
  logic            inflight;
  logic [CT_W-1:0] fifo_data [2];
  logic [AW-1:0]   fifo_idx  [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      fifo_cnt;
  logic [CT_W-1:0] comp_word;
  logic            pop;
  logic            push;
  logic            issue;
  logic            last_pop;

  compress_du10_x8 u_compress (
    .coef_word (M0_RData),
    .ct_word   (comp_word)
  );

  // A read is only issued when its result is guaranteed a FIFO slot, counting
  // the word already in flight and the slot freed by this cycle's pop.
  assign pop      = ct_valid & ct_ready;
  assign push     = inflight;
  assign issue    = (state == ST_RUN) &&
                    (({1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop}) < 3'd2);
  assign last_pop = pop && (ct_WAd == AW'(N_WORDS - 1));
  assign done     = (state == ST_DRAIN) && last_pop;
  assign ct_valid = (fifo_cnt != 2'd0);
  assign ct_WData = fifo_data[rd_ptr];
  assign ct_WAd   = fifo_idx[rd_ptr];
  assign M0_RAd   = rd_cnt;

  // Run control: state, read address counter and the one-cycle inflight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      rd_cnt       <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_idx <= rd_cnt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            busy   <= 1'b1;
            rd_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (rd_cnt == AW'(N_WORDS - 1)) state <= ST_DRAIN;
            else                            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            rd_cnt <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output FIFO; the head entry drives the stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_idx[0]  <= '0;
      fifo_idx[1]  <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= comp_word;
        fifo_idx[wr_ptr]  <= inflight_idx;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_u_compress_reader.sv
// Bench for enc_u_compress_reader: BRAM model, stream monitor and a
// direct-formula reference for the du=10 compression.
module tb_enc_u_compress_reader;

  localparam int N_WORDS = 64;
  localparam int AW      = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] M0_RAd;
  logic [95:0]   M0_RData;
  logic [79:0]   ct_WData;
  logic [AW-1:0] ct_WAd;
  logic          ct_valid;
  logic          ct_ready;

  logic [95:0] mem [N_WORDS];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_idx = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_hs = 0;
  int last_hs = 0;
  int ovf = 0;
  logic          hold_v = 1'b0;
  logic [79:0]   hold_dat = '0;
  logic [AW-1:0] hold_ad = '0;
  logic [79:0]   lane_seen = '0;
  bit            rand_mode = 1'b0;

  enc_u_compress_reader #(.N_WORDS(N_WORDS), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .M0_RAd   (M0_RAd),
    .M0_RData (M0_RData),
    .ct_WData (ct_WData),
    .ct_WAd   (ct_WAd),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous-read BRAM: data one cycle after the address.
  always @(posedge clk) M0_RData <= mem[M0_RAd];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [79:0] ref_word(input int a);
    logic [95:0] w;
    logic [79:0] r;
    int x;
    w = mem[a];
    r = '0;
    for (int i = 0; i < 8; i++) begin
      x = int'(w[12*i +: 12]);
      r[10*i +: 10] = 10'(((x * 1024 + 1664) / 3329) % 1024);
    end
    return r;
  endfunction

  // Stream monitor: order, content, stall stability, done placement.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_idx = 0;
      hold_v  = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 96'(ct_valid), 96'(1));
        check("hold_data", 96'(ct_WData), 96'(hold_dat));
        check("hold_addr", 96'(ct_WAd), 96'(hold_ad));
      end
      if (dut.inflight && dut.fifo_cnt == 2'd2 && !(ct_valid && ct_ready)) ovf++;
      if (ct_valid && ct_ready) begin
        check("ct_WAd", 96'(ct_WAd), 96'(exp_idx));
        check("ct_WData", 96'(ct_WData), 96'(ref_word(exp_idx)));
        if (exp_idx == 0) first_hs = cyc;
        if (exp_idx == N_WORDS - 1) last_hs = cyc;
        if (exp_idx == 5) lane_seen = ct_WData;
        exp_idx = (exp_idx + 1) % N_WORDS;
        hs_cnt++;
      end
      hold_v   = ct_valid && !ct_ready;
      hold_dat = ct_WData;
      hold_ad  = ct_WAd;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_on_last_hs", 96'(cyc), 96'(last_hs));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) ct_ready = ($urandom_range(0, 99) >= 30);
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k;
    k = 0;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", 96'(done_cnt != base), 96'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 96'(busy), 96'(0));
    check({tag, "_done"}, 96'(done), 96'(0));
    check({tag, "_valid"}, 96'(ct_valid), 96'(0));
    check({tag, "_rad"}, 96'(M0_RAd), 96'(0));
    check({tag, "_wdata"}, 96'(ct_WData), 96'(0));
    check({tag, "_wad"}, 96'(ct_WAd), 96'(0));
  endtask

  task automatic fill_random();
    for (int a = 0; a < N_WORDS; a++)
      for (int i = 0; i < 8; i++) mem[a][12*i +: 12] = 12'($urandom_range(0, 4095));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int base_d;
    int base_h;
    int lanes [8];
    int elanes [8];
    logic [79:0] exp_lane;

    lanes  = '{0, 1, 1664, 1665, 3328, 4095, 2, 3327};
    elanes = '{0, 0, 512, 512, 0, 236, 1, 1023};
    for (int a = 0; a < N_WORDS; a++) mem[a] = '0;
    rst_n = 1'b0;
    start = 1'b0;
    ct_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Constant data, ready held high: exact latency and done timing.
    for (int a = 0; a < N_WORDS; a++)
      for (int i = 0; i < 8; i++) mem[a][12*i +: 12] = 12'(a * 51);
    base_d = done_cnt;
    base_h = hs_cnt;
    do_start(s);
    check("busy_c1", 96'(busy), 96'(1));
    check("rad_c1", 96'(M0_RAd), 96'(0));
    check("valid_c1", 96'(ct_valid), 96'(0));
    tick();
    check("valid_c2", 96'(ct_valid), 96'(0));
    tick();
    check("valid_c3", 96'(ct_valid), 96'(1));
    wait_done(base_d, 200);
    check("done_cycle", 96'(done_cyc - s), 96'(66));
    check("busy_c67", 96'(busy), 96'(0));
    check("words_const", 96'(hs_cnt - base_h), 96'(64));

    // Lane boundary word placed at address 5.
    fill_random();
    for (int i = 0; i < 8; i++) mem[5][12*i +: 12] = 12'(lanes[i]);
    for (int i = 0; i < 8; i++) exp_lane[10*i +: 10] = 10'(elanes[i]);
    base_d = done_cnt;
    do_start(s);
    wait_done(base_d, 200);
    check("lane_bounds", 96'(lane_seen), 96'(exp_lane));
    check("lane0_bits", 96'(lane_seen[9:0]), 96'(0));

    // Random backpressure with random data.
    fill_random();
    base_d = done_cnt;
    base_h = hs_cnt;
    rand_mode = 1'b1;
    do_start(s);
    wait_done(base_d, 2000);
    rand_mode = 1'b0;
    ct_ready = 1'b1;
    check("words_bp", 96'(hs_cnt - base_h), 96'(64));
    tick();

    // Consumer stalled for 10 cycles right after start.
    fill_random();
    base_d = done_cnt;
    ct_ready = 1'b0;
    do_start(s);
    repeat (9) tick();
    check("stall_rad", 96'(M0_RAd), 96'(2));
    check("stall_wad", 96'(ct_WAd), 96'(0));
    check("stall_valid", 96'(ct_valid), 96'(1));
    ct_ready = 1'b1;
    wait_done(base_d, 200);
    check("stall_b2b", 96'(last_hs - first_hs), 96'(63));

    // Reset asserted mid-run, then a fresh run.
    fill_random();
    base_d = done_cnt;
    base_h = hs_cnt;
    do_start(s);
    for (int k = 0; k < 200 && (hs_cnt - base_h) < 20; k++) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_no_done", 96'(done_cnt), 96'(base_d));
    check("abort_idle", 96'(busy), 96'(0));
    base_h = hs_cnt;
    do_start(s);
    wait_done(base_d, 200);
    check("rerun_words", 96'(hs_cnt - base_h), 96'(64));
    check("rerun_one_done", 96'(done_cnt - base_d), 96'(1));

    // Start pulses while busy and on the done cycle are ignored.
    fill_random();
    base_d = done_cnt;
    base_h = hs_cnt;
    do_start(s);
    for (int k = 2; k <= 80; k++) begin
      tick();
      start = (k == 10 || k == 30 || k == 66);
    end
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("ignore_one_done", 96'(done_cnt - base_d), 96'(1));
    check("ignore_words", 96'(hs_cnt - base_h), 96'(64));
    check("ignore_busy", 96'(busy), 96'(0));
    check("ignore_valid", 96'(ct_valid), 96'(0));
    check("ignore_done_cycle", 96'(done_cyc - s), 96'(66));

    check("fifo_overflow", 96'(ovf), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/enc_u_compress_reader.md
# enc_u_compress_reader

Reads the NTT/poly BRAM word-by-word after the `DEC_ENC_INTT`/`ENC_Add` stages and drives the `u` vector toward the packer. The poly BRAM holds 64 words of 96 bits, each word carrying 8 × 12-bit coefficients. For each word the block applies Kyber512 Compress_q(x, du=10) to all 8 coefficients and emits one 80-bit compressed word over a valid/ready stream. It is the read side of the BRAM interface that the decompress/NTT write path fills, and produces the 640-byte `u` portion of the ciphertext.

## Interface
Parameters:
- `N_WORDS`, 64: words per run (k=2 polys × 32 words).
- `AW`, 6: BRAM address width.

Ports:
- `clk`, in, 1: single clock; all logic rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a run; ignored while `busy`.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last output handshake.
- `M0_RAd`, out, AW: BRAM read address.
- `M0_RData`, in, 96: BRAM read data, valid one cycle after `M0_RAd`.
- `ct_WData`, out, 80: compressed word. Lane i is at [10i+9:10i] and comes from source bits [12i+11:12i].
- `ct_WAd`, out, AW: index of the current output word, 0..63.
- `ct_valid`, out, 1: output word valid.
- `ct_ready`, in, 1: consumer accepts the word when `ct_valid` and `ct_ready` are both high.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`.
  - RUN→DRAIN after the read of address N_WORDS-1 is issued.
  - DRAIN→IDLE on the handshake of word N_WORDS-1; `done` pulses in that same transition cycle.
- Read issue:
  - The read counter `rd_cnt` starts at 0 and `M0_RAd` = `rd_cnt`.
  - A read issues in RUN when (fifo_count + inflight − pop) < 2, where pop = `ct_valid` & `ct_ready`.
  - `rd_cnt` increments on each issue and never wraps within a run.
- Inflight: 1-bit flag, set on issue and cleared the next cycle, when `M0_RData` is captured.
- Compression, per lane:
  - y = floor((x·1024 + 1664) / 3329) mod 1024, with x the unsigned 12-bit lane value.
  - Result must be bit-exact for x in 0..3328.
  - For x ≥ 3329 the same formula applies and the result is truncated to 10 bits; no error flag.
- Buffer: 2-entry FIFO of {80-bit data, 6-bit index}, written with the compressed `M0_RData` in the capture cycle.
  - `ct_valid` = FIFO non-empty; `ct_WData`/`ct_WAd` = FIFO head.
  - Simultaneous push and pop: count unchanged and order preserved.
  - Push while full is impossible by the issue rule; verification asserts this.
- Output words leave strictly in address order 0..63, no gaps and no duplicates.
- `start` arriving in the same cycle as `done`: ignored (block not yet IDLE).

## Timing
- Reset values: `busy`=0, `done`=0, `ct_valid`=0, `M0_RAd`=0, `ct_WData`=0, `ct_WAd`=0. FSM=IDLE, counters=0, FIFO empty.
- Reset asserted mid-run aborts at once; no `done`. The next `start` after release begins a fresh run at address 0.
- `start` at cycle 0 → `busy`=1 at cycle 1 and first read issued at cycle 1 → data at cycle 2 → `ct_valid`=1 at cycle 3.
- With `ct_ready` held high: one word per cycle, last handshake at cycle 66, `done` at cycle 66, `busy`=0 at cycle 67.
- `ct_ready` low: the FIFO fills to 2, issue stalls, `M0_RAd` holds. Throughput resumes the cycle `ct_ready` returns, with no bubble.
- `ct_WData`/`ct_WAd` stay stable while `ct_valid`=1 and `ct_ready`=0.

## Structure
- Shared package `kyber_pkg`: KYBER_Q=3329, DU=10, COEF_W=12, COEFS_PER_WORD=8, N_WORDS=64, state encodings.
- Sub-module `compress_du10_x8`: combinational, 96-bit in, 80-bit out, 8 lanes of the compress formula. Implemented with a constant-multiply and shift that is verified exhaustive-exact over 0..3328.
- Top level: FSM, read counter, inflight flag, 2-entry FIFO.

## Test plan
- Constant data: BRAM word a holds all lanes = a·51 (≤3213); `ct_ready`=1; `start` → 64 words, word a lanes = floor((a·51·1024+1664)/3329). `done` at cycle 66.
- Lane boundaries: lanes {0, 1, 1664, 1665, 3328, 4095, 2, 3327} → {0, 0, 512, 512, 0, 236, 1, 1023}; lane 0 at bits [9:0].
- Backpressure: `ct_ready` random 30 % low → same 64 words in order, data stable while stalled, FIFO never overflows, `M0_RAd` never exceeds 63.
- `ct_ready`=0 for 10 cycles after `start` → exactly 2 reads issued; `ct_WAd`=0 held; on release, words 0..63 follow back-to-back.
- `rst_n` pulled low at word 20 → all outputs return to reset values immediately; a new `start` yields words 0..63 and a single `done`.
- `start` pulses while busy and on the `done` cycle → no restart, exactly one `done` per accepted `start`.
